// File: rtl/branch_resolve_bp.sv
// Execute-stage branch resolver with a 2-bit saturating BHT and a held mispredict redirect.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_resolve_bp #(
   parameter int BHT_ENTRIES = 16,
   parameter int BHT_IDX_W   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [1:0]  br_type,
   input  logic [1:0]  comp_result,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_imm,
   input  logic        pred_taken_in,
   input  logic [31:0] fetch_pc,
   output logic        fetch_pred_taken,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_count,
   output logic [31:0] mispredict_count
);

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_e;

   state_e                 state_q;
   logic [31:0]            redirect_pc_q;
   logic [1:0]             bht_q [BHT_ENTRIES];
   logic [1:0]             bht_entry_d;
   logic                   accept_s;
   logic                   taken_s;
   logic                   mispredict_s;
   logic [31:0]            target_s;
   logic [31:0]            fall_s;
   logic [31:0]            correct_pc_s;
   logic [BHT_IDX_W-1:0]   br_idx_s;
   logic [BHT_IDX_W-1:0]   fetch_idx_s;
   logic                   unused_fetch_s;

   // Comparator code 3 is invalid and never yields a taken branch.
   function automatic logic resolve_taken(input logic [1:0] typ, input logic [1:0] cmp);
      logic t;
      t = 1'b0;
      if (cmp == 2'd3) begin
         t = 1'b0;
      end else begin
         case (typ)
            2'b00:   t = (cmp != 2'd0);
            2'b01:   t = (cmp == 2'd1);
            2'b10:   t = (cmp == 2'd2);
            2'b11:   t = (cmp == 2'd0);
            default: t = 1'b0;
         endcase
      end
      return t;
   endfunction

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
      logic [1:0] r;
      r = ctr;
      if (up) begin
         r = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
      end else begin
         r = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
      end
      return r;
   endfunction

   assign br_idx_s         = br_pc[BHT_IDX_W-1:0];
   assign fetch_idx_s      = fetch_pc[BHT_IDX_W-1:0];
   assign unused_fetch_s   = ^fetch_pc[31:BHT_IDX_W];
   assign br_ready         = (state_q == ST_IDLE) | redirect_ready;
   assign accept_s         = br_valid & br_ready;
   assign redirect_valid   = (state_q == ST_REDIRECT);
   assign redirect_pc      = redirect_pc_q;
   assign fetch_pred_taken = bht_q[fetch_idx_s][1];

   // Branch outcome, corrected PC and the updated counter for the resolving entry.
   always_comb begin
      taken_s      = 1'b0;
      mispredict_s = 1'b0;
      bht_entry_d  = bht_q[br_idx_s];
      fall_s       = br_pc + 32'd1;
      target_s     = br_pc + 32'd1 + br_imm;
      taken_s      = resolve_taken(br_type, comp_result);
      mispredict_s = (taken_s != pred_taken_in);
      correct_pc_s = taken_s ? target_s : fall_s;
      bht_entry_d  = sat_update(bht_q[br_idx_s], taken_s);
   end

   // Redirect FSM; a mispredicted accept in REDIRECT implies the old redirect handed off this edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         redirect_pc_q <= 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s && mispredict_s) begin
                  state_q       <= ST_REDIRECT;
                  redirect_pc_q <= correct_pc_s;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_REDIRECT: begin
               if (accept_s && mispredict_s) begin
                  state_q       <= ST_REDIRECT;
                  redirect_pc_q <= correct_pc_s;
               end else if (accept_s || redirect_ready) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_REDIRECT;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Branch history table; fetch reads the registered value, so a same-cycle update is seen next cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (accept_s) begin
         bht_q[br_idx_s] <= bht_entry_d;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] br_count_q;
   logic [31:0] mispredict_count_q;

   // Resolved-branch and mispredict statistics, free-running with wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         br_count_q         <= 32'd0;
         mispredict_count_q <= 32'd0;
      end else if (accept_s) begin
         br_count_q <= br_count_q + 32'd1;
         if (mispredict_s) begin
            mispredict_count_q <= mispredict_count_q + 32'd1;
         end
      end
   end

   assign br_count         = br_count_q;
   assign mispredict_count = mispredict_count_q;
`else
   assign br_count         = 32'd0;
   assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_bp.sv
// Randomized and directed bench for branch_resolve_bp against a branch-level reference model.
module tb_branch_resolve_bp;

   logic        clock = 1'b0;
   logic        reset;
   logic        br_valid;
   logic        br_ready;
   logic [1:0]  br_type;
   logic [1:0]  comp_result;
   logic [31:0] br_pc;
   logic [31:0] br_imm;
   logic        pred_taken_in;
   logic [31:0] fetch_pc;
   logic        fetch_pred_taken;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] mispredict_count;

`ifdef BP_STATS_EN
   localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] STAT_MASK = 32'h0000_0000;
`endif

   int          tests_run    = 0;
   int          tests_failed = 0;

   // Reference model: counter value per entry, pending redirect, statistics.
   int          bht_m [16];
   bit          rv_m;
   logic [31:0] rpc_m;
   logic [31:0] bc_m;
   logic [31:0] mc_m;

   branch_resolve_bp #(.BHT_ENTRIES(16), .BHT_IDX_W(4)) dut (
      .clock(clock), .reset(reset),
      .br_valid(br_valid), .br_ready(br_ready),
      .br_type(br_type), .comp_result(comp_result),
      .br_pc(br_pc), .br_imm(br_imm), .pred_taken_in(pred_taken_in),
      .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc),
      .br_count(br_count), .mispredict_count(mispredict_count)
   );

   always #5 clock = ~clock;

   function automatic bit model_taken(input logic [1:0] typ, input logic [1:0] cmp);
      int c;
      c = int'(cmp);
      if (c == 3) return 1'b0;
      if (typ == 2'b00) return c != 0;
      if (typ == 2'b01) return c == 1;
      if (typ == 2'b10) return c == 2;
      return c == 0;
   endfunction

   task automatic reset_model();
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
      rv_m  = 1'b0;
      rpc_m = 32'd0;
      bc_m  = 32'd0;
      mc_m  = 32'd0;
   endtask

   // Advance the model by one branch-level step, then clock the DUT.
   task automatic tick();
      bit acc, tk;
      int idx;
      acc = br_valid && (!rv_m || redirect_ready);
      if (acc) begin
         tk  = model_taken(br_type, comp_result);
         idx = int'(br_pc[3:0]);
         if (tk && bht_m[idx] < 3) bht_m[idx] = bht_m[idx] + 1;
         else if (!tk && bht_m[idx] > 0) bht_m[idx] = bht_m[idx] - 1;
         bc_m = bc_m + 32'd1;
         if (tk != pred_taken_in) begin
            mc_m  = mc_m + 32'd1;
            rv_m  = 1'b1;
            rpc_m = tk ? (br_pc + 32'd1 + br_imm) : (br_pc + 32'd1);
         end else begin
            rv_m = 1'b0;
         end
      end else if (rv_m && redirect_ready) begin
         rv_m = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic set_br(input bit v, input logic [1:0] t, input logic [1:0] c,
                         input logic [31:0] pc, input logic [31:0] imm, input bit p);
      br_valid = v; br_type = t; comp_result = c;
      br_pc = pc; br_imm = imm; pred_taken_in = p;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      br_valid = 1'b0; redirect_ready = 1'b0;
      set_br(1'b0, 2'b00, 2'd0, 32'd0, 32'd0, 1'b0);
      fetch_pc = 32'd5;
      #1;
      reset_model();
      tests_run++;
      if (redirect_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rv: got %0b expected 0", redirect_valid); end
      tests_run++;
      if (redirect_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_rpc: got %h expected 0", redirect_pc); end
      tests_run++;
      if (br_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %0b expected 1", br_ready); end
      tests_run++;
      if (fetch_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_pred5: got %0b expected 0", fetch_pred_taken); end
      tests_run++;
      if (br_count !== 32'd0 || mispredict_count !== 32'd0) begin
         tests_failed++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", br_count, mispredict_count);
      end
      for (int i = 0; i < 16; i++) begin
         fetch_pc = i;
         #1;
         tests_run++;
         if (fetch_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_bht idx %0d: got %0b expected 0", i, fetch_pred_taken); end
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_blt_redirect();
      redirect_ready = 1'b0;
      set_br(1'b1, 2'b01, 2'd1, 32'h10, 32'h4, 1'b0);
      #1;
      tests_run++;
      if (br_ready !== 1'b1) begin tests_failed++; $display("FAIL blt_ready: got %0b expected 1", br_ready); end
      tick();
      br_valid = 1'b0;
      fetch_pc = 32'h0;
      #1;
      tests_run++;
      if (redirect_valid !== 1'b1) begin tests_failed++; $display("FAIL blt_rv: got %0b expected 1", redirect_valid); end
      tests_run++;
      if (redirect_pc !== 32'h15) begin tests_failed++; $display("FAIL blt_rpc: got %h expected 00000015", redirect_pc); end
      tests_run++;
      if (fetch_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL blt_bht0: got %0b expected 1", fetch_pred_taken); end
   endtask

   task automatic test_hold();
      redirect_ready = 1'b0;
      set_br(1'b1, 2'b11, 2'd0, 32'h7, 32'h0, 1'b0);
      fetch_pc = 32'h7;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests_run++;
         if (br_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_ready %0d: got %0b expected 0", k, br_ready); end
         tick();
         tests_run++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 32'h15) begin
            tests_failed++; $display("FAIL hold_rv %0d: got %0b/%h expected 1/00000015", k, redirect_valid, redirect_pc);
         end
         tests_run++;
         if (fetch_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL hold_noupd %0d: got %0b expected 0", k, fetch_pred_taken); end
      end
      br_valid = 1'b0;
      redirect_ready = 1'b1;
      tick();
      tests_run++;
      if (redirect_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_release: got %0b expected 0", redirect_valid); end
   endtask

   task automatic test_bht_saturate();
      int exp_ctr [6];
      int prev;
      exp_ctr = '{2, 3, 3, 3, 2, 1};
      redirect_ready = 1'b1;
      fetch_pc = 32'h3;
      prev = 1;
      for (int k = 0; k < 6; k++) begin
         set_br(1'b1, 2'b11, (k < 4) ? 2'd0 : 2'd2, 32'h3, 32'h8, 1'b1);
         #1;
         tests_run++;
         if (fetch_pred_taken !== (prev >= 2)) begin
            tests_failed++; $display("FAIL sat_pre %0d: got %0b expected %0b", k, fetch_pred_taken, prev >= 2);
         end
         tick();
         tests_run++;
         if (fetch_pred_taken !== (exp_ctr[k] >= 2)) begin
            tests_failed++; $display("FAIL sat_post %0d: got %0b expected %0b", k, fetch_pred_taken, exp_ctr[k] >= 2);
         end
         prev = exp_ctr[k];
      end
      br_valid = 1'b0;
      tests_run++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4) begin
         tests_failed++; $display("FAIL sat_redirect: got %0b/%h expected 1/00000004", redirect_valid, redirect_pc);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      redirect_ready = 1'b1;
      set_br(1'b1, 2'b00, 2'd0, 32'hFFFF_FFFF, 32'h5, 1'b1);
      tick();
      tests_run++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
         tests_failed++; $display("FAIL wrap_fall: got %0b/%h expected 1/00000000", redirect_valid, redirect_pc);
      end
      set_br(1'b1, 2'b01, 2'd1, 32'h1234, 32'hFFFF_FFFF, 1'b0);
      #1;
      tests_run++;
      if (br_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %0b expected 1", br_ready); end
      tick();
      tests_run++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1234) begin
         tests_failed++; $display("FAIL b2b_target: got %0b/%h expected 1/00001234", redirect_valid, redirect_pc);
      end
      br_valid = 1'b0;
      tick();
      tests_run++;
      if (redirect_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got %0b expected 0", redirect_valid); end
   endtask

   task automatic test_stats_and_async_reset();
      logic [1:0] t_tab [5];
      logic [1:0] c_tab [5];
      bit         p_tab [5];
      t_tab = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
      c_tab = '{2'd0,  2'd2,  2'd2,  2'd1,  2'd3};
      p_tab = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
      test_reset();
      redirect_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_br(1'b1, t_tab[k], c_tab[k], 32'h20 + k, 32'h2, p_tab[k]);
         tick();
      end
      br_valid = 1'b0;
      #1;
      tests_run++;
      if (br_count !== (32'd5 & STAT_MASK)) begin tests_failed++; $display("FAIL stats_br: got %0d expected %0d", br_count, 32'd5 & STAT_MASK); end
      tests_run++;
      if (mispredict_count !== (32'd2 & STAT_MASK)) begin
         tests_failed++; $display("FAIL stats_mis: got %0d expected %0d", mispredict_count, 32'd2 & STAT_MASK);
      end
      redirect_ready = 1'b0;
      set_br(1'b1, 2'b01, 2'd1, 32'h40, 32'h10, 1'b0);
      tick();
      br_valid = 1'b0;
      tests_run++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h51) begin
         tests_failed++; $display("FAIL areset_pre: got %0b/%h expected 1/00000051", redirect_valid, redirect_pc);
      end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
         tests_failed++; $display("FAIL areset_rv: got %0b/%h expected 0/00000000", redirect_valid, redirect_pc);
      end
      tests_run++;
      if (br_count !== 32'd0 || mispredict_count !== 32'd0) begin
         tests_failed++; $display("FAIL areset_stats: got %0d/%0d expected 0/0", br_count, mispredict_count);
      end
      reset_model();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         br_valid       = ($urandom_range(0, 3) != 0);
         br_type        = 2'($urandom_range(0, 3));
         comp_result    = 2'($urandom_range(0, 3));
         br_pc          = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 63));
         br_imm         = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 31));
         pred_taken_in  = 1'($urandom_range(0, 1));
         redirect_ready = 1'($urandom_range(0, 1));
         fetch_pc       = 32'($urandom_range(0, 63));
         #1;
         tests_run++;
         if (br_ready !== (!rv_m || redirect_ready)) begin
            tests_failed++; $display("FAIL rand_ready %0d: got %0b expected %0b", n, br_ready, !rv_m || redirect_ready);
         end
         tests_run++;
         if (fetch_pred_taken !== (bht_m[fetch_pc[3:0]] >= 2)) begin
            tests_failed++; $display("FAIL rand_pred %0d: got %0b expected %0b", n, fetch_pred_taken, bht_m[fetch_pc[3:0]] >= 2);
         end
         tick();
         tests_run++;
         if (redirect_valid !== rv_m || redirect_pc !== rpc_m) begin
            tests_failed++; $display("FAIL rand_redirect %0d: got %0b/%h expected %0b/%h", n, redirect_valid, redirect_pc, rv_m, rpc_m);
         end
         tests_run++;
         if (br_count !== (bc_m & STAT_MASK) || mispredict_count !== (mc_m & STAT_MASK)) begin
            tests_failed++; $display("FAIL rand_stats %0d: got %0d/%0d expected %0d/%0d", n, br_count, mispredict_count,
                                     bc_m & STAT_MASK, mc_m & STAT_MASK);
         end
      end
      br_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_blt_redirect();
      test_hold();
      test_bht_saturate();
      test_back_to_back();
      test_stats_and_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
